sprite_layer_renderer: RTL and testbench

SPRITE_LAYER_RENDERER -- requirements
Module: sprite_layer_renderer

---
 rtl/sprite_pkg.sv | 35 +++
 rtl/sprite_channel.sv | 71 +++++++
 rtl/sprite_layer_renderer.sv | 138 +++++++++++++
 tb/tb_sprite_layer_renderer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: direction encoding, transparent palette index,
// the per-channel sprite state record, the texture ROM contents and the
// palette mapping.
//   texel_index : address -> palette index (ROM contents, 4-bit indices)
//   palette_rgb : palette index -> 12-bit RGB {r,g,b}
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    dir_e       dir;
    logic       en;
  } sprite_state_t;

  // Texture pattern: xor-fold of the address nibbles plus one. Index 0
  // (transparent) appears wherever the fold is all ones.
  function automatic logic [IDX_W-1:0] texel_index(input logic [15:0] addr);
    return (addr[3:0] ^ addr[7:4] ^ addr[11:8] ^ addr[15:12]) + 4'd1;
  endfunction

  function automatic logic [11:0] palette_rgb(input logic [IDX_W-1:0] idx);
    return {idx, ~idx, idx ^ 4'h5};
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: hit test, direction transform and synchronous ROM.
//   vga_clk, reset_n : pixel clock, async active-low reset
//   DrawX, DrawY     : current pixel position
//   state            : active sprite state {x,y,dir,en}
//   hit, idx         : registered hit flag and ROM index, two cycles after
//                      DrawX/DrawY
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_DIM    = 32,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  sprite_state_t    state,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned C    = $clog2(SPR_DIM);
  localparam int unsigned AW   = 2 * C;
  localparam logic [10:0] SPAN = 11'(SPR_DIM << SCALE_LOG2);

  logic [10:0]   dx, dy;
  logic          in_x, in_y, hit_c;
  logic [C-1:0]  u, v, row, col;
  logic [AW-1:0] addr_c, addr_q;
  logic          hit_q;

  // Bounds are compared at 11 bits so a sprite near column 1023 clips
  // instead of wrapping onto column 0.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, state.x};
    dy     = {1'b0, DrawY} - {1'b0, state.y};
    in_x   = ({1'b0, DrawX} >= {1'b0, state.x}) &&
             ({1'b0, DrawX} <  ({1'b0, state.x} + SPAN));
    in_y   = ({1'b0, DrawY} >= {1'b0, state.y}) &&
             ({1'b0, DrawY} <  ({1'b0, state.y} + SPAN));
    hit_c  = state.en && in_x && in_y;
    u      = C'(dx >> SCALE_LOG2);
    v      = C'(dy >> SCALE_LOG2);
    row    = v;
    col    = u;
    // D-1-n is the bitwise complement because SPR_DIM is a power of two.
    case (state.dir)
      DIR_UP:    begin row = v;  col = u;  end
      DIR_DOWN:  begin row = ~v; col = ~u; end
      DIR_RIGHT: begin row = ~u; col = v;  end
      DIR_LEFT:  begin row = u;  col = ~v; end
      default:   begin row = v;  col = u;  end
    endcase
    addr_c = {row, col};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      hit_q  <= '0;
      idx    <= '0;
      hit    <= '0;
    end else begin
      addr_q <= addr_c;
      hit_q  <= hit_c;
      idx    <= texel_index(16'(addr_q));
      hit    <= hit_q;
    end
  end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Sprite layer: NUM_SPRITES channels with double-buffered state, priority
// select, shared palette and registered RGB output (3-cycle latency).
//   vga_clk, reset_n       : pixel clock, async active-low reset
//   DrawX, DrawY, blank    : pixel position, high = active video
//   frame_start            : one-cycle pulse; shadow -> active, collide update
//   upd_*                  : shadow-register update handshake
//   red, green, blue       : registered 4-bit colour
//   collide                : an opaque overlap was seen in the previous frame
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPR_DIM     = 32,
  parameter int unsigned SCALE_LOG2  = 1,
  parameter logic [11:0] BG_RGB      = 12'h000,
  localparam int unsigned ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            blank,
  input  logic            frame_start,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [ID_W-1:0] upd_id,
  input  logic [9:0]      upd_x,
  input  logic [9:0]      upd_y,
  input  logic [1:0]      upd_dir,
  input  logic            upd_en,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue,
  output logic            collide
);

  sprite_state_t shadow_q [NUM_SPRITES];
  sprite_state_t active_q [NUM_SPRITES];
  logic          ready_q;
  logic          upd_fire;

  logic [NUM_SPRITES-1:0] ch_hit;
  logic [IDX_W-1:0]       ch_idx [NUM_SPRITES];

  logic             blank_d1, blank_d2;
  logic             win_found, multi, overlap;
  logic [IDX_W-1:0] win_idx;
  logic [11:0]      pix_rgb, rgb_q;
  logic             sticky_q;

  always_comb begin
    upd_ready = ready_q & ~frame_start;
    upd_fire  = upd_valid & upd_ready;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      ready_q <= '1;
      if (frame_start) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (upd_fire && (32'(upd_id) < NUM_SPRITES)) begin
        shadow_q[upd_id] <= '{x: upd_x, y: upd_y, dir: dir_e'(upd_dir), en: upd_en};
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .SPR_DIM    (SPR_DIM),
      .SCALE_LOG2 (SCALE_LOG2)
    ) u_ch (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .DrawX   (DrawX),
      .DrawY   (DrawY),
      .state   (active_q[g]),
      .hit     (ch_hit[g]),
      .idx     (ch_idx[g])
    );
  end

  // Lowest-numbered opaque channel wins; a second opaque one flags overlap.
  always_comb begin
    win_found = '0;
    win_idx   = '0;
    multi     = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (ch_hit[i] && (ch_idx[i] != TRANSPARENT_IDX)) begin
        if (win_found) begin
          multi = '1;
        end else begin
          win_found = '1;
          win_idx   = ch_idx[i];
        end
      end
    end
    pix_rgb = win_found ? palette_rgb(win_idx) : BG_RGB;
    overlap = blank_d2 & multi;
  end

  // An overlap coinciding with frame_start belongs to the new frame, so
  // it seeds the sticky flag rather than feeding collide.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d1 <= '0;
      blank_d2 <= '0;
      rgb_q    <= '0;
      sticky_q <= '0;
      collide  <= '0;
    end else begin
      blank_d1 <= blank;
      blank_d2 <= blank_d1;
      rgb_q    <= blank_d2 ? pix_rgb : '0;
      if (frame_start) begin
        collide  <= sticky_q;
        sticky_q <= overlap;
      end else if (overlap) begin
        sticky_q <= '1;
      end
    end
  end

  always_comb begin
    red   = rgb_q[11:8];
    green = rgb_q[7:4];
    blue  = rgb_q[3:0];
  end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
module tb_sprite_layer_renderer;

  localparam int NS    = 4;
  localparam int D     = 32;
  localparam int SCALE = 2;
  localparam int SPAN  = D * SCALE;
  localparam logic [11:0] BG = 12'h123;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank, frame_start;
  logic       upd_valid, upd_ready;
  logic [1:0] upd_id;
  logic [9:0] upd_x, upd_y;
  logic [1:0] upd_dir;
  logic       upd_en;
  logic [3:0] red, green, blue;
  logic       collide;

  sprite_layer_renderer #(
    .NUM_SPRITES (NS),
    .SPR_DIM     (D),
    .SCALE_LOG2  (1),
    .BG_RGB      (BG)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_id      (upd_id),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_dir     (upd_dir),
    .upd_en      (upd_en),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .collide     (collide)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x;
    int y;
    int d;
    bit en;
  } mst_t;

  typedef struct {
    logic [11:0] rgb;
    bit          ov;
    bit          blank;
    int          x;
    int          y;
  } ent_t;

  mst_t        shadow_m [NS];
  mst_t        active_m [NS];
  ent_t        pipe [$];
  bit          sticky_m, collide_m, rdy_m;
  logic [11:0] obs [int];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int tex(input int a);
    return ((a ^ (a >> 4) ^ (a >> 8) ^ (a >> 12)) + 1) % 16;
  endfunction

  function automatic logic [11:0] pal(input int i);
    return 12'((i << 8) | ((15 - i) << 4) | (i ^ 5));
  endfunction

  function automatic ent_t model_pixel(input int px, input int py, input bit bl);
    ent_t e;
    int n, widx, u, v, row, col, idx;
    bit found;
    n = 0; widx = 0; found = 0;
    for (int c = 0; c < NS; c++) begin
      if (active_m[c].en && px >= active_m[c].x && px < active_m[c].x + SPAN &&
          py >= active_m[c].y && py < active_m[c].y + SPAN) begin
        u = (px - active_m[c].x) / SCALE;
        v = (py - active_m[c].y) / SCALE;
        case (active_m[c].d)
          0:       begin row = v;         col = u;         end
          1:       begin row = D - 1 - u; col = v;         end
          2:       begin row = D - 1 - v; col = D - 1 - u; end
          default: begin row = u;         col = D - 1 - v; end
        endcase
        idx = tex(row * D + col);
        if (idx != 0) begin
          n++;
          if (!found) begin found = 1; widx = idx; end
        end
      end
    end
    e.rgb   = bl ? (found ? pal(widx) : BG) : 12'h000;
    e.ov    = bl && (n >= 2);
    e.blank = bl;
    e.x     = px;
    e.y     = py;
    return e;
  endfunction

  task automatic model_reset();
    ent_t z;
    z = '{rgb: 12'h000, ov: 0, blank: 0, x: 0, y: 0};
    for (int c = 0; c < NS; c++) begin
      shadow_m[c] = '{x: 0, y: 0, d: 0, en: 0};
      active_m[c] = '{x: 0, y: 0, d: 0, en: 0};
    end
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    sticky_m = 0; collide_m = 0; rdy_m = 0;
  endtask

  task automatic tick();
    ent_t e, o;
    e = model_pixel(int'(DrawX), int'(DrawY), blank);
    pipe.push_back(e);
    #1;
    chk("upd_ready", {11'd0, upd_ready}, {11'd0, rdy_m && !frame_start});
    @(posedge vga_clk);
    o = pipe.pop_front();
    if (frame_start) begin
      collide_m = sticky_m;
      sticky_m  = o.ov;
      for (int c = 0; c < NS; c++) active_m[c] = shadow_m[c];
    end else if (o.ov) begin
      sticky_m = 1;
    end
    if (upd_valid && rdy_m && !frame_start)
      shadow_m[upd_id] = '{x: int'(upd_x), y: int'(upd_y), d: int'(upd_dir), en: upd_en};
    rdy_m = 1;
    #1;
    chk("rgb", {red, green, blue}, o.rgb);
    chk("collide", {11'd0, collide}, {11'd0, collide_m});
    if (o.blank) obs[o.y * 1024 + o.x] = {red, green, blue};
  endtask

  task automatic drive(input int x, input int y, input bit bl, input bit fs,
                       input bit uv, input int id, input int ux, input int uy,
                       input int ud, input bit ue);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_start = fs;
    upd_valid = uv; upd_id = 2'(id); upd_x = 10'(ux); upd_y = 10'(uy);
    upd_dir = 2'(ud); upd_en = ue;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic upd(input int id, input int x, input int y, input int d, input bit en);
    drive(0, 0, 0, 0, 1, id, x, y, d, en);
    tick();
  endtask

  task automatic frame();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      drive(x, y, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic chk_px(input string tag, input int x, input int y, input logic [11:0] exp);
    int k;
    k = y * 1024 + x;
    chk(tag, obs.exists(k) ? obs[k] : 12'hxxx, exp);
  endtask

  initial begin
    int px, py, ux, uy;
    bit bl, fs, uv, ue;

    // Power-on reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("reset_rgb", {red, green, blue}, 12'h000);
    chk("reset_collide", {11'd0, collide}, 12'h000);
    chk("reset_ready", {11'd0, upd_ready}, 12'h000);
    reset_n = 1'b1;
    model_reset();
    idle(2);

    // Upright sprite, scale 2
    upd(0, 100, 50, 0, 1);
    frame();
    scan(50, 95, 170);
    scan(51, 99, 102);
    idle(3);
    chk_px("up_100_50", 100, 50, 12'h1E4);
    chk_px("up_101_51", 101, 51, 12'h1E4);
    chk_px("up_102_50", 102, 50, 12'h2D7);
    chk_px("up_163_50", 163, 50, 12'hF0A);
    chk_px("left_edge_99", 99, 50, BG);
    chk_px("right_edge_164", 164, 50, BG);

    // Orientation variants
    upd(0, 100, 50, 2, 1); frame(); scan(50, 100, 101); idle(3);
    chk_px("down_addr1023", 100, 50, 12'h4B1);
    upd(0, 100, 50, 1, 1); frame(); scan(50, 100, 101); idle(3);
    chk_px("right_addr992", 100, 50, 12'hE1B);
    upd(0, 100, 50, 3, 1); frame(); scan(50, 100, 101); idle(3);
    chk_px("left_addr31", 100, 50, 12'hF0A);

    // Overlap / collision
    upd(0, 200, 200, 0, 1);
    upd(1, 200, 200, 2, 1);
    frame();
    chk("collide_pre", {11'd0, collide}, 12'h000);
    scan(200, 200, 203);
    idle(3);
    chk_px("prio_ch0", 200, 200, 12'h1E4);
    chk("collide_same_frame", {11'd0, collide}, 12'h000);
    frame();
    chk("collide_next_frame", {11'd0, collide}, 12'h001);
    upd(1, 400, 400, 0, 1);
    frame();
    scan(200, 200, 203);
    idle(3);
    frame();
    chk("collide_clear", {11'd0, collide}, 12'h000);

    // Update offered during frame_start stalls one cycle
    upd(2, 300, 300, 0, 1);
    frame();
    drive(0, 0, 0, 1, 1, 2, 320, 300, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1, 2, 320, 300, 0, 1);
    tick();
    scan(300, 300, 300); scan(300, 320, 320); idle(3);
    chk_px("old_pos_kept", 300, 300, 12'h1E4);
    chk_px("old_pos_u10", 320, 300, 12'hB4E);
    frame();
    scan(300, 300, 300); scan(300, 320, 320); idle(3);
    chk_px("new_pos_vacated", 300, 300, BG);
    chk_px("new_pos_drawn", 320, 300, 12'h1E4);

    // Right-edge clipping
    upd(3, 1000, 10, 0, 1);
    frame();
    scan(10, 995, 1023);
    scan(10, 0, 45);
    idle(3);
    chk_px("clip_999", 999, 10, BG);
    chk_px("clip_1000", 1000, 10, 12'h1E4);
    chk_px("clip_1023", 1023, 10, 12'hC39);
    chk_px("nowrap_0", 0, 10, BG);
    chk_px("nowrap_39", 39, 10, BG);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) px = $urandom_range(0, 1023);
      else                           px = $urandom_range(90, 340);
      py = $urandom_range(90, 340);
      bl = ($urandom_range(0, 9) != 0);
      fs = ($urandom_range(0, 49) == 0);
      uv = ($urandom_range(0, 9) == 0);
      ue = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) ux = $urandom_range(960, 1023);
      else                           ux = $urandom_range(100, 260);
      uy = $urandom_range(100, 260);
      drive(px, py, bl, fs, uv, $urandom_range(0, 3), ux, uy, $urandom_range(0, 3), ue);
      tick();
    end

    // Reset in the middle of a line
    upd(0, 200, 200, 0, 1); upd(1, 210, 200, 0, 1); frame();
    scan(200, 200, 230);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_rgb", {red, green, blue}, 12'h000);
    chk("midreset_collide", {11'd0, collide}, 12'h000);
    chk("midreset_ready", {11'd0, upd_ready}, 12'h000);
    repeat (2) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    scan(200, 200, 203);
    frame();
    scan(200, 204, 206);
    idle(3);
    chk_px("post_reset_bg", 200, 200, BG);
    chk_px("post_reset_bg_frame", 205, 200, BG);
    upd(0, 200, 200, 0, 1);
    frame();
    scan(200, 200, 201);
    idle(3);
    chk_px("post_reset_sprite", 200, 200, 12'h1E4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
